// File: rtl/dcm_rst_seq_if.sv
// Signal bundle between the reset/lock sequencer and the two-stage DCM chain.
// The slave side is the sequencer. The master side is the DCM/board logic,
// which drives the ready lines and consumes the resets.
interface dcm_rst_seq_if;
    logic       dcm0_ready;
    logic       dcm1_ready;
    logic       dcm0_rst;
    logic       dcm1_rst;
    logic       sys_rst_b;
    logic       locked;
    logic       fault;
    logic [3:0] retry_cnt;

    modport master (
        output dcm0_ready, dcm1_ready,
        input  dcm0_rst, dcm1_rst, sys_rst_b, locked, fault, retry_cnt
    );

    modport slave (
        input  dcm0_ready, dcm1_ready,
        output dcm0_rst, dcm1_rst, sys_rst_b, locked, fault, retry_cnt
    );
endinterface

// File: rtl/dcm_rst_seq.sv
// Reset/lock sequencer for the two-stage clock chain (mult_dcm -> clk100_dcm).
// Stage 0 is brought up first. Stage 1 is released after a settle window.
// System reset is released only after both stages report lock.
// Lock timeouts are retried. Repeated timeouts end in a sticky FAULT state,
// which only rst can clear.
module dcm_rst_seq #(
    parameter int unsigned RST_CYCLES    = 4,
    parameter int unsigned SETTLE_CYCLES = 15,
    parameter int unsigned LOCK_TIMEOUT  = 1000,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic          clk,
    input  logic          rst,
    dcm_rst_seq_if.slave  bus
);

    localparam int unsigned CNT_MAX_A = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > LOCK_TIMEOUT) ? CNT_MAX_A : LOCK_TIMEOUT;
    localparam int unsigned CW        = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        RST0,
        WAIT0,
        SETTLE,
        RST1,
        WAIT1,
        RUN,
        FAULT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    retry_q, retry_d;
    logic [1:0]    sync0_q, sync1_q;
    logic          r0, r1;
    logic          timeout;

    assign r0 = sync0_q[1];
    assign r1 = sync1_q[1];

    // Two-flop synchronizers for the asynchronous DCM ready lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync0_q <= '0;
            sync1_q <= '0;
        end else begin
            sync0_q <= {sync0_q[0], bus.dcm0_ready};
            sync1_q <= {sync1_q[0], bus.dcm1_ready};
        end
    end

    // Next-state, counter and retry logic.
    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        case (state_q)
            RST0: begin
                if (cnt_q == RST_LAST) state_d = WAIT0;
            end
            WAIT0: begin
                if (r0) begin
                    state_d = SETTLE;
                end else if (cnt_q == TO_LAST) begin
                    timeout = 1'b1;
                    state_d = RST0;
                end
            end
            SETTLE: begin
                if (!r0)                       state_d = RST0;
                else if (cnt_q == SETTLE_LAST) state_d = WAIT1;
            end
            RST1: begin
                if (!r0)                    state_d = RST0;
                else if (cnt_q == RST_LAST) state_d = WAIT1;
            end
            WAIT1: begin
                if (!r0) begin
                    state_d = RST0;
                end else if (r1) begin
                    state_d = RUN;
                end else if (cnt_q == TO_LAST) begin
                    timeout = 1'b1;
                    state_d = RST1;
                end
            end
            RUN: begin
                if (!r0)      state_d = RST0;
                else if (!r1) state_d = RST1;
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = RST0;
            end
        endcase

        // The retry budget is checked after the per-state decision, so a
        // timeout on the last allowed attempt goes to FAULT instead of retrying.
        retry_d = retry_q;
        if (timeout) begin
            if (retry_q == RETRY_MAX) begin
                state_d = FAULT;
            end else if (retry_q != 4'hF) begin
                retry_d = retry_q + 4'd1;
            end
        end
        if (state_d == RUN && state_q != RUN) retry_d = '0;

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == RUN || state_q == FAULT) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // State register, plus registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RST0;
            cnt_q         <= '0;
            retry_q       <= '0;
            bus.dcm0_rst  <= 1'b1;
            bus.dcm1_rst  <= 1'b1;
            bus.sys_rst_b <= 1'b0;
            bus.locked    <= 1'b0;
            bus.fault     <= 1'b0;
            bus.retry_cnt <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            bus.dcm0_rst  <= (state_d == RST0) || (state_d == FAULT);
            bus.dcm1_rst  <= (state_d != WAIT1) && (state_d != RUN);
            bus.sys_rst_b <= (state_d == RUN);
            bus.locked    <= (state_d == RUN);
            bus.fault     <= (state_d == FAULT);
            bus.retry_cnt <= retry_d;
        end
    end

endmodule

// File: doc/dcm_rst_seq.md
Name: dcm_rst_seq

Overview:
- Reset/lock sequencer for the two-stage clock chain.
- Stage 0 is a mult_dcm, fed by the board reference clock. Stage 1 is clk100_dcm, fed from the stage-0 output.
- The block releases the stage-0 DCM reset first and waits for lock. It then holds the stage-1 DCM in reset for a settle window, releases it, and waits for lock before deasserting system reset.
- Runs on the reference clock. Recovers from lock timeouts and lock loss; enters a sticky fault state after repeated failures.

Parameters:
RST_CYCLES, 4, cycles each DCM reset is held asserted per attempt (minimum 1)
SETTLE_CYCLES, 15, cycles after stage-0 lock before stage-1 reset is released (minimum 1)
LOCK_TIMEOUT, 1000, cycles allowed for a DCM ready to assert after its reset is released (minimum 1)
MAX_RETRY, 3, timeout retries allowed before FAULT (4 attempts in total)

Ports:
clk  in  1  reference clock; all logic on posedge
rst  in  1  synchronous, active-high reset
dcm0_ready  in  1  stage-0 DCM ready; asynchronous, passes through a 2-flop synchronizer
dcm1_ready  in  1  stage-1 DCM ready; asynchronous, passes through a 2-flop synchronizer
dcm0_rst  out  1  stage-0 DCM reset, active high
dcm1_rst  out  1  stage-1 DCM reset, active high
sys_rst_b  out  1  system reset, active low; high only in RUN
locked  out  1  high only in RUN
fault  out  1  high only in FAULT
retry_cnt  out  4  timeout retries since last RUN entry; saturates at 15

Behaviour:
- All outputs are registered.
- Reset (rst=1 at a clock edge):
  - state=RST0, counter=0, retry_cnt=0.
  - dcm0_rst=1, dcm1_rst=1, sys_rst_b=0, locked=0, fault=0.
  - Synchronizer flops clear to 0.
  - State is held while rst=1; rst overrides every state, including FAULT.
- r0/r1 denote the synchronized readies. They lag the raw inputs by 2 cycles.
- The counter clears on every state entry. A timed state exits on the cycle its counter equals N-1, so it lasts exactly N cycles.
- RST0: dcm0_rst=1, dcm1_rst=1.
  - After RST_CYCLES → WAIT0.
- WAIT0: dcm0_rst=0, dcm1_rst=1.
  - r0=1 → SETTLE.
  - Else counter==LOCK_TIMEOUT-1 → timeout.
- SETTLE: dcm0_rst=0, dcm1_rst=1.
  - r0=0 → RST0 (no retry increment).
  - Else after SETTLE_CYCLES → WAIT1.
- RST1: dcm0_rst=0, dcm1_rst=1.
  - r0=0 → RST0.
  - Else after RST_CYCLES → WAIT1.
- WAIT1: dcm0_rst=0, dcm1_rst=0.
  - r0=0 → RST0.
  - Else r1=1 → RUN.
  - Else counter==LOCK_TIMEOUT-1 → timeout.
- RUN: dcm0_rst=0, dcm1_rst=0, sys_rst_b=1, locked=1. retry_cnt clears on entry.
  - r0=0 → RST0 (r0 takes priority when both readies drop).
  - Else r1=0 → RST1.
- Timeout handling:
  - retry_cnt==MAX_RETRY → FAULT.
  - Otherwise retry_cnt+1. The next state is RST0 from WAIT0, RST1 from WAIT1.
- FAULT: dcm0_rst=1, dcm1_rst=1, sys_rst_b=0, fault=1. Exits only via rst.
- Lock loss never increments retry_cnt. Only timeouts do.
- sys_rst_b falls on the same edge the state leaves RUN: 3 cycles after the raw ready falls.
- A ready assertion shorter than 1 cycle may be missed; this is acceptable.

Test Plan:
1. Nominal. rst=1 for 3 cycles, then 0. Model: dcm0_ready rises 20 cycles after dcm0_rst falls; dcm1_ready rises 10 cycles after dcm1_rst falls.
   - dcm0_rst falls 4 cycles after rst deasserts.
   - dcm1_rst falls 22+15=37 cycles after dcm0_rst falls.
   - sys_rst_b and locked rise 12 cycles after dcm1_rst falls; retry_cnt=0.
2. Stage-0 timeout. dcm0_ready held at 0.
   - dcm0_rst pulses high 4 cycles every 1004 cycles; retry_cnt steps 1, 2, 3.
   - After the 4th timeout: fault=1, both DCM resets stay high indefinitely.
   - Then rst=1 for 1 cycle → fault=0, retry_cnt=0, sequence restarts.
3. Stage-1 lock loss in RUN. dcm1_ready drops for 1 cycle.
   - sys_rst_b=0 and dcm1_rst=1 three cycles later; dcm0_rst stays 0.
   - dcm1_rst is high exactly 4 cycles, then WAIT1; RUN is re-entered after relock.
4. Stage-0 lock loss in RUN. dcm0_ready and dcm1_ready drop together.
   - Both DCM resets assert 3 cycles later (RST0, not RST1); full sequence replays as in scenario 1.
5. Stage-1 single timeout. dcm1_ready stays 0 for the first attempt, then rises 5 cycles into the second.
   - retry_cnt=1 during the retry; RUN entered; retry_cnt returns to 0 on RUN entry.
6. Mid-sequence reset. rst pulsed 1 cycle during SETTLE (counter=7).
   - Next edge: dcm0_rst=1, dcm1_rst=1, state RST0, counter=0.
   - Sequence then matches scenario 1 from the rst release.
